// File: rtl/seg_scan_if.sv
// Bus bundle between the scan controller and its host/display driver.
// The master drives the frame-buffer and scan controls; the slave returns the digit drive.
interface seg_scan_if #(
  parameter int unsigned NUM_DIGITS = 8
) ();
  logic                      enable;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   data;
  logic [NUM_DIGITS-1:0]     blank_mask;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [3:0]                nibble;
  logic [NUM_DIGITS-1:0]     digit_sel;
  logic                      dp;
  logic                      pending;
  logic                      frame_done;

  modport master (
    output enable, load, data, blank_mask, dp_in,
    input  nibble, digit_sel, dp, pending, frame_done
  );

  modport slave (
    input  enable, load, data, blank_mask, dp_in,
    output nibble, digit_sel, dp, pending, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a blanking guard per slot and a
// shadowed frame buffer that is committed only at frame boundaries.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned CLK_DIV      = 10000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_scan_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0]               cnt_q,     cnt_d;
  logic [IDX_W-1:0]               idx_q,     idx_d;
  logic [NUM_DIGITS-1:0][3:0]     display_q, display_d;
  logic [NUM_DIGITS-1:0][3:0]     shadow_q,  shadow_d;
  logic                           pending_q, pending_d;

  logic last_cnt_c;
  logic last_idx_c;
  logic frame_end_c;
  logic commit_c;

  assign last_cnt_c  = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign last_idx_c  = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign frame_end_c = bus.enable & last_idx_c & last_cnt_c;
  // A disabled edge is treated like a frame boundary so held data lands promptly.
  assign commit_c    = ~bus.enable | frame_end_c;

  // Slot counter and digit index.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!bus.enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (last_cnt_c) begin
      cnt_d = '0;
      idx_d = last_idx_c ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Shadow capture and frame-boundary commit; a load on the boundary bypasses the shadow.
  always_comb begin
    display_d = display_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (commit_c) begin
      if (bus.load) begin
        display_d = bus.data;
        shadow_d  = bus.data;
        pending_d = 1'b0;
      end else if (pending_q) begin
        display_d = shadow_q;
        pending_d = 1'b0;
      end
    end else if (bus.load) begin
      shadow_d  = bus.data;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      display_q <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      display_q <= display_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  // Moore decode of the digit drive; masked digits keep their slot but stay dark.
  always_comb begin
    bus.digit_sel = '0;
    bus.dp        = 1'b0;
    if (bus.enable && (cnt_q >= CNT_W'(BLANK_CYCLES)) && !bus.blank_mask[idx_q]) begin
      bus.digit_sel = NUM_DIGITS'(1) << idx_q;
      bus.dp        = bus.dp_in[idx_q];
    end
  end

  assign bus.nibble     = display_q[idx_q];
  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_end_c;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios followed by random traffic,
// all compared against a frame-position reference model.
module tb_seg_scan_ctrl;

  localparam int unsigned ND    = 4;
  localparam int unsigned DIV   = 8;
  localparam int unsigned BLANK = 2;
  localparam int unsigned FRAME = ND * DIV;

  logic clk = 1'b0;
  logic rst_n;

  seg_scan_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .CLK_DIV     (DIV),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: cycles since scan start, displayed and shadowed frames.
  int          m_t;
  logic [15:0] m_disp;
  logic [15:0] m_sh;
  logic        m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic chk_outs();
    int pos, idx, cnt;
    logic on;
    logic [3:0] exp_sel;
    #1;
    pos = m_t % FRAME;
    idx = pos / DIV;
    cnt = pos % DIV;
    on  = bus.enable && (cnt >= BLANK) && !bus.blank_mask[idx];
    exp_sel = on ? 4'(1 << idx) : 4'd0;
    check("digit_sel",  32'(bus.digit_sel),  32'(exp_sel));
    check("dp",         32'(bus.dp),         32'(on & bus.dp_in[idx]));
    check("nibble",     32'(bus.nibble),     32'(m_disp[idx*4 +: 4]));
    check("pending",    32'(bus.pending),    32'(m_pend));
    check("frame_done", 32'(bus.frame_done), 32'(bus.enable && (pos == FRAME - 1)));
    check("sel_onehot0", 32'($onehot0(bus.digit_sel)), 32'd1);
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic step();
    int          n_t;
    logic [15:0] n_disp, n_sh;
    logic        n_pend, boundary;
    n_t = m_t; n_disp = m_disp; n_sh = m_sh; n_pend = m_pend;
    if (!rst_n) begin
      n_t = 0; n_disp = '0; n_sh = '0; n_pend = 1'b0;
    end else begin
      boundary = bus.enable && ((m_t % FRAME) == FRAME - 1);
      if (!bus.enable || boundary) begin
        if (bus.load) begin
          n_disp = bus.data; n_sh = bus.data; n_pend = 1'b0;
        end else if (m_pend) begin
          n_disp = m_sh; n_pend = 1'b0;
        end
      end else if (bus.load) begin
        n_sh = bus.data; n_pend = 1'b1;
      end
      n_t = bus.enable ? m_t + 1 : 0;
    end
    @(posedge clk);
    #1;
    m_t = n_t; m_disp = n_disp; m_sh = n_sh; m_pend = n_pend;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      chk_outs();
      step();
    end
  endtask

  task automatic pulse_load(input logic [15:0] d);
    bus.load = 1'b1;
    bus.data = d;
    run(1);
    bus.load = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.enable     = 1'b0;
    bus.load       = 1'b0;
    bus.data       = '0;
    bus.blank_mask = '0;
    bus.dp_in      = '0;
    m_t = 0; m_disp = '0; m_sh = '0; m_pend = 1'b0;
    step();
    step();
    chk_outs();

    // Scan from reset with a mid-frame load deferred to the boundary.
    rst_n      = 1'b1;
    bus.enable = 1'b1;
    run(5);
    pulse_load(16'h1234);
    #1 check("pend_after_load", 32'(bus.pending), 32'd1);
    run(26);
    #1 check("commit_nibble_d0", 32'(bus.nibble), 32'h4);
    check("commit_pending", 32'(bus.pending), 32'd0);
    run(16);
    #1 check("slot2_nibble", 32'(bus.nibble), 32'h2);
    run(15);

    // Load on the boundary edge, then two loads in one frame.
    pulse_load(16'hABCD);
    #1 check("direct_pending", 32'(bus.pending), 32'd0);
    check("direct_nibble", 32'(bus.nibble), 32'hD);
    run(6);
    pulse_load(16'h1111);
    run(4);
    pulse_load(16'h2222);
    run(20);
    #1 check("last_load_wins", 32'(bus.nibble), 32'h2);

    // Masked digit and decimal points.
    bus.blank_mask = 4'b0100;
    bus.dp_in      = 4'b0101;
    run(2);
    #1 check("dp_digit0_on", 32'(bus.dp), 32'd1);
    run(30);

    // Reset mid-scan with pending data.
    pulse_load(16'h5555);
    run(20);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    #1 check("rst_sel", 32'(bus.digit_sel), 32'd0);
    check("rst_nibble", 32'(bus.nibble), 32'd0);
    check("rst_pending", 32'(bus.pending), 32'd0);
    run(10);

    // Disable with pending data, then re-enable.
    pulse_load(16'h7777);
    bus.enable = 1'b0;
    run(1);
    #1 check("dis_sel", 32'(bus.digit_sel), 32'd0);
    check("dis_commit", 32'(bus.nibble), 32'h7);
    run(2);
    bus.enable = 1'b1;
    run(2);
    #1 check("reen_sel", 32'(bus.digit_sel), 32'b0001);
    bus.blank_mask = '0;

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      bus.enable = ($urandom_range(0, 59) != 0);
      bus.load   = bus.enable && ($urandom_range(0, 7) == 0);
      bus.data   = 16'($urandom);
      if ((c % 16) == 0) begin
        bus.blank_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
        bus.dp_in      = 4'($urandom);
      end
      run(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-cathode 7-segment digits sharing one hex-to-segment decoder.
- Holds a frame buffer of hex nibbles and steps a one-hot digit select through the digits.
- Presents each digit's nibble to the shared decoder, with a blanking guard between digits to suppress ghosting.
- Frame-buffer updates go through a shadow register and are committed only at a frame boundary, so a frame never shows a mix of old and new values.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (≥2).
- CLK_DIV, 10000, clock cycles per digit slot (>BLANK_CYCLES).
- BLANK_CYCLES, 16, cycles at the start of each slot with all digits off (≥1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous reset, active-low.
- enable  input  1  scan enable.
- load  input  1  single-cycle strobe; capture data into the shadow register.
- data  input  4*NUM_DIGITS  hex nibbles; digit i = data[4i+3:4i].
- blank_mask  input  NUM_DIGITS  1 = digit i never lit.
- dp_in  input  NUM_DIGITS  decimal point per digit.
- nibble  output  4  hex value to the shared decoder's input.
- digit_sel  output  NUM_DIGITS  one-hot active-high digit enable.
- dp  output  1  decimal point for the current digit.
- pending  output  1  shadow holds uncommitted data.
- frame_done  output  1  high on the last cycle of each frame.

Behaviour:
- Clock and reset:
  - One clock domain.
  - rst_n is sampled on the rising clk edge; low clears every register.
- Reset values:
  - cnt=0, idx=0, display=0, shadow=0, pending=0.
  - Outputs: digit_sel=0, nibble=0, dp=0, frame_done=0.
- Counters:
  - cnt runs 0..CLK_DIV-1.
  - At cnt==CLK_DIV-1: cnt←0 and idx←idx+1.
  - idx wraps from NUM_DIGITS-1 to 0. This edge is the frame boundary.
- Phases (Moore outputs, decoded from registered state in the same cycle):
  - BLANK, while cnt<BLANK_CYCLES: digit_sel=0, dp=0.
  - ON, while cnt≥BLANK_CYCLES: digit_sel=one-hot(idx) unless blank_mask[idx]=1, in which case digit_sel=0. dp=dp_in[idx] & ~blank_mask[idx].
  - Slot timing is unchanged for masked digits.
  - nibble=display[4*idx+3:4*idx] at all times, including BLANK.
- Load/commit:
  - load=1 on an edge: shadow←data, pending←1.
  - Frame-boundary edge with pending=1: display←shadow, pending←0.
  - load on the frame-boundary edge itself: display←data directly; shadow←data; pending stays 0.
  - Repeated loads before commit: last one wins; one commit only.
- enable=0:
  - Next edge: cnt←0, idx←0; digit_sel=0 and dp=0 while low.
  - Any pending shadow commits on that edge.
  - A load while disabled commits on the following edge.
  - When enable returns to 1, the scan restarts at idx=0, cnt=0, BLANK phase.
- frame_done = enable & (idx==NUM_DIGITS-1) & (cnt==CLK_DIV-1); 1 cycle per frame.
- Frame period: NUM_DIGITS*CLK_DIV cycles.
- At most one digit_sel bit is ever high. Digit i turns off ≥BLANK_CYCLES cycles before digit i+1 turns on.
- Reset mid-scan or mid-pending: the next cycle shows reset values; shadow data is discarded.
- blank_mask and dp_in are sampled live (no shadowing).

Test Plan:
All scenarios use NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2.
1. Release reset, enable=1, data=0 → cycles 0–1 digit_sel=0000; cycles 2–7 digit_sel=0001, nibble=0; cycle 8 BLANK; cycles 10–15 digit_sel=0010; frame_done high only at cycle 31.
2. load with data=16'h1234 at cycle 5 → pending=1 from cycle 6; nibble stays 0 through cycle 31; at cycle 32 pending=0, nibble=4 (digit0), digit2 slot (cycles 48–55) nibble=2.
3. load with data=16'hABCD on the cycle-31 edge → no pending cycle; cycle 32 nibble=D; two loads mid-frame (16'h1111 then 16'h2222) → only 2222 ever displayed.
4. blank_mask=4'b0100, dp_in=4'b0101 → digit_sel never 0100, dp never high during the digit2 slot; dp=1 in the digit0 ON phase; frame still 32 cycles.
5. rst_n low for 1 cycle at idx=2, cnt=5, pending=1 → next cycle all outputs 0, display=0; scan restarts at idx0 with 0000 shown; pending=0.
6. enable=0 at idx=1 with pending=1 → digit_sel=0000, display updated next edge; enable=1 → digit_sel=0000 for 2 cycles, then 0001.
